seq_mul_unit: RTL and testbench



---
 rtl/mul_pkg.sv | 15 +
 rtl/seq_mul_unit_if.sv | 27 ++
 rtl/mul_shift_datapath.sv | 65 ++++++
 rtl/seq_mul_unit.sv | 132 +++++++++++++
 tb/tb_seq_mul_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the legal operand width range.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  localparam int MUL_MIN_WIDTH = 4;
  localparam int MUL_MAX_WIDTH = 64;

endpackage

// File: rtl/seq_mul_unit_if.sv
// Request/response bundle of the sequential multiplier. The requester
// (ALU or bench) uses the master view, the multiplier the slave view.
interface seq_mul_unit_if #(
  parameter int WIDTH = 32
);

  logic                   Start;
  logic                   Abort;
  logic                   Signed_mode;
  logic [WIDTH-1:0]       Multiplicand_in;
  logic [WIDTH-1:0]       Multiplier_in;
  logic                   Ready;
  logic                   Busy;
  logic                   Done;
  logic [2*WIDTH-1:0]     Product;

  modport master (
    output Start, Abort, Signed_mode, Multiplicand_in, Multiplier_in,
    input  Ready, Busy, Done, Product
  );

  modport slave (
    input  Start, Abort, Signed_mode, Multiplicand_in, Multiplier_in,
    output Ready, Busy, Done, Product
  );

endinterface

// File: rtl/mul_shift_datapath.sv
// Working state of the shift-add multiplier: multiplicand magnitude,
// double-width accumulator (upper half = partial sum, lower half = remaining
// multiplier bits) and the sign of the final result. Sequenced by the
// load/step/fix enables of the controlling FSM.
module mul_shift_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 fix,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic               neg_r;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_neg_s;

  // Unsigned magnitude of an operand. In signed mode the most-negative value
  // negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic sm);
    if (sm && x[WIDTH-1]) begin
      mag = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag = x;
    end
  endfunction

  // One extra bit keeps the carry of the partial-sum add; it shifts into the
  // top accumulator bit.
  assign sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
  assign acc_neg_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign result    = neg_r ? acc_neg_s : acc_r;

  // Load operands, perform one shift-add iteration, or apply the sign fix.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
    end else if (load) begin
      mcand_r <= mag(a, signed_mode);
      acc_r   <= {{WIDTH{1'b0}}, mag(b, signed_mode)};
      neg_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      if (acc_r[0]) begin
        acc_r <= {sum_s, acc_r[WIDTH-1:1]};
      end else begin
        acc_r <= {1'b0, acc_r[2*WIDTH-1:1]};
      end
    end else if (fix) begin
      acc_r <= result;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier, one iteration per clock,
// with start/done handshake, abort and signed/unsigned mode. The requester
// only ever sees the held Product register, never the working accumulator.
module seq_mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           Reset,
  seq_mul_unit_if.slave  bus
);

  generate
    if (WIDTH < MUL_MIN_WIDTH || WIDTH > MUL_MAX_WIDTH) begin : g_bad_width
      $error("seq_mul_unit: WIDTH out of supported range");
    end
  endgenerate

  mul_state_e          state_r;
  mul_state_e          state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                load_s;
  logic                step_s;
  logic                fix_s;
  logic                done_r;
  logic [2*WIDTH-1:0]  product_r;
  logic [2*WIDTH-1:0]  result_s;

  mul_shift_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk         (clk),
    .Reset       (Reset),
    .load        (load_s),
    .step        (step_s),
    .fix         (fix_s),
    .signed_mode (bus.Signed_mode),
    .a           (bus.Multiplicand_in),
    .b           (bus.Multiplier_in),
    .result      (result_s)
  );

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath enables; Abort only acts while working, Start
  // beats a simultaneous Abort in IDLE.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    fix_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.Abort) begin
          state_s = IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_s = FIX;
          end else begin
            state_s = RUN;
          end
        end
      end
      FIX: begin
        if (bus.Abort) begin
          state_s = IDLE;
        end else begin
          fix_s   = 1'b1;
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Iteration counter, cleared on load and advanced once per RUN step.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (step_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture: the sign-corrected value is registered on the edge that
  // enters DONE, so Product and the Done pulse appear together in DONE.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      product_r <= {(2*WIDTH){1'b0}};
      done_r    <= 1'b0;
    end else if (fix_s) begin
      product_r <= result_s;
      done_r    <= 1'b1;
    end else begin
      product_r <= product_r;
      done_r    <= 1'b0;
    end
  end

  assign bus.Ready   = (state_r == IDLE);
  assign bus.Busy    = (state_r == RUN) || (state_r == FIX);
  assign bus.Done    = done_r;
  assign bus.Product = product_r;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: drivers push expected products and start
// cycles, per-instance monitors pop and compare on every Done pulse.
module tb_seq_mul_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sw_rst_n;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- main WIDTH=32 instance ----------------
  seq_mul_unit_if #(.WIDTH(W)) mi ();
  seq_mul_unit #(.WIDTH(W)) dut (.clk(clk), .Reset(rst_n), .bus(mi));

  logic [2*W-1:0] exp_q[$];
  int unsigned    cyc_q[$];

  // Monitor: each Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mi.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", mi.Done, 1'b0);
      end else begin
        check("product", mi.Product, exp_q.pop_front());
        check("latency", cyc - cyc_q.pop_front(), W + 1);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (mi.Ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mi.Ready !== 1'b1) check("ready_timeout", mi.Ready, 1'b1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sm, input bit abt, input bit expect_done,
                       input logic [2*W-1:0] e);
    wait_ready();
    mi.Start = 1'b1;
    mi.Abort = abt;
    mi.Signed_mode = sm;
    mi.Multiplicand_in = a;
    mi.Multiplier_in = b;
    @(posedge clk);
    #1;
    mi.Start = 1'b0;
    mi.Abort = 1'b0;
    mi.Signed_mode = ~sm;
    mi.Multiplicand_in = 32'hDEAD_BEEF;
    mi.Multiplier_in = 32'h1234_5678;
    if (expect_done) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
    end
  endtask

  // ---------------- WIDTH sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SW = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    seq_mul_unit_if #(.WIDTH(SW)) sif ();
    seq_mul_unit #(.WIDTH(SW)) u_dut (.clk(clk), .Reset(sw_rst_n), .bus(sif));
    logic [2*SW-1:0] sq[$];
    int unsigned     sc[$];
    bit              fin = 1'b0;

    // Monitor for this width.
    always @(negedge clk) begin
      if (sif.Done === 1'b1) begin
        if (sq.size() == 0) begin
          check($sformatf("w%0d_unexpected_done", SW), sif.Done, 1'b0);
        end else begin
          check($sformatf("w%0d_product", SW), sif.Product, sq.pop_front());
          check($sformatf("w%0d_latency", SW), cyc - sc.pop_front(), SW + 1);
        end
      end
    end

    // Driver: two edge cases, then random signed/unsigned pairs.
    initial begin
      logic [SW-1:0]   a, b;
      logic [2*SW-1:0] e;
      bit              sm;
      int              n;
      sif.Start = 1'b0;
      sif.Abort = 1'b0;
      sif.Signed_mode = 1'b0;
      sif.Multiplicand_in = '0;
      sif.Multiplier_in = '0;
      wait (sw_rst_n === 1'b1);
      for (int i = 0; i < 66; i++) begin
        if (i == 0) begin
          a = '1; b = '1; sm = 1'b0;
        end else if (i == 1) begin
          a = '0; a[SW-1] = 1'b1; b = a; sm = 1'b1;
        end else begin
          a = SW'($urandom()); b = SW'($urandom()); sm = 1'($urandom_range(0, 1));
        end
        if (sm) begin
          e = $signed(a) * $signed(b);
        end else begin
          e = a * b;
        end
        if (SW == 4 && i == 0) e = 8'hE1;
        if (SW == 4 && i == 1) e = 8'h40;
        n = 0;
        @(negedge clk);
        while (sif.Ready !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (sif.Ready !== 1'b1) check($sformatf("w%0d_ready_timeout", SW), sif.Ready, 1'b1);
        sif.Start = 1'b1;
        sif.Signed_mode = sm;
        sif.Multiplicand_in = a;
        sif.Multiplier_in = b;
        @(posedge clk);
        #1;
        sif.Start = 1'b0;
        sif.Multiplicand_in = ~a;
        sif.Multiplier_in = ~b;
        sq.push_back(e);
        sc.push_back(cyc);
      end
      n = 0;
      while (sq.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("w%0d_drain", SW), sq.size(), 0);
      fin = 1'b1;
    end
  end

  // ---------------- main directed sequence ----------------
  initial begin
    int  n;
    bit  rl;
    rst_n = 1'b0;
    sw_rst_n = 1'b0;
    mi.Start = 1'b0;
    mi.Abort = 1'b0;
    mi.Signed_mode = 1'b0;
    mi.Multiplicand_in = '0;
    mi.Multiplier_in = '0;
    #23;
    check("rst_ready", mi.Ready, 1'b1);
    check("rst_busy", mi.Busy, 1'b0);
    check("rst_done", mi.Done, 1'b0);
    check("rst_product", mi.Product, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sw_rst_n = 1'b1;

    // Unsigned max; Ready must stay low until and including the Done cycle.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("busy_in_run", mi.Busy, 1'b1);
    rl = 1'b1;
    n = 0;
    while (mi.Done !== 1'b1 && n < 100) begin
      if (mi.Ready !== 1'b0) rl = 1'b0;
      @(negedge clk);
      n++;
    end
    if (mi.Ready !== 1'b0) rl = 1'b0;
    check("done_seen", mi.Done, 1'b1);
    check("ready_low_while_working", rl, 1'b1);

    // Signed vectors.
    issue(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0001);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 64'h4000_0000_0000_0000);

    // 7x6, then 9x9 aborted at iteration 10.
    issue(32'd7, 32'd6, 1'b0, 1'b0, 1'b1, 64'd42);
    issue(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (10) @(posedge clk);
    #1 mi.Abort = 1'b1;
    @(posedge clk);
    #1 mi.Abort = 1'b0;
    @(negedge clk);
    check("abort_ready", mi.Ready, 1'b1);
    check("abort_busy", mi.Busy, 1'b0);
    repeat (W + 5) @(negedge clk);
    check("abort_product_held", mi.Product, 64'd42);

    // Start while busy is ignored.
    issue(32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 64'd6);
    repeat (5) @(negedge clk);
    mi.Start = 1'b1;
    mi.Multiplicand_in = 32'd100;
    mi.Multiplier_in = 32'd100;
    @(negedge clk);
    mi.Start = 1'b0;
    wait_ready();
    repeat (W + 5) @(negedge clk);
    check("busy_start_ignored", mi.Product, 64'd6);

    // Abort together with Start in IDLE: Start wins.
    issue(32'd11, 32'd13, 1'b0, 1'b1, 1'b1, 64'd143);

    // Abort while in FIX.
    issue(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (W) @(posedge clk);
    #1 mi.Abort = 1'b1;
    @(posedge clk);
    #1 mi.Abort = 1'b0;
    @(negedge clk);
    check("fix_abort_ready", mi.Ready, 1'b1);
    repeat (4) @(negedge clk);
    check("fix_abort_product_held", mi.Product, 64'd143);

    // Asynchronous reset between edges mid-RUN.
    issue(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_product", mi.Product, 64'h0);
    check("async_rst_busy", mi.Busy, 1'b0);
    check("async_rst_ready", mi.Ready, 1'b1);
    check("async_rst_done", mi.Done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 64'd12);
    wait_ready();
    repeat (3) @(negedge clk);
    check("main_drain", exp_q.size(), 0);

    n = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("sweep_complete", {g_sw[0].fin, g_sw[1].fin, g_sw[2].fin}, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
